// File: rtl/psum_pkg.sv
// Shared types and constants for the psum accumulate / stream controller.
package psum_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Job modes.
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Largest value representable in a signed lane of bw bits.
  function automatic int sat_max(input int bw);
    return (32'sd1 <<< (bw - 1)) - 32'sd1;
  endfunction

  // Smallest value representable in a signed lane of bw bits.
  function automatic int sat_min(input int bw);
    return -(32'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_lane_sat.sv
// One psum lane: widened signed add, clamp to lane range, optional ReLU.
// With acc_i tied to zero it degenerates to a plain ReLU stage.
module psum_lane_sat
  import psum_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic [BW-1:0] acc_i,
  input  logic [BW-1:0] add_i,
  input  logic          relu_en_i,
  output logic [BW-1:0] res_o,
  output logic          sat_o
);

  localparam logic signed [BW:0] MAX_V = (BW + 1)'(sat_max(BW));
  localparam logic signed [BW:0] MIN_V = (BW + 1)'(sat_min(BW));

  logic signed [BW:0] sum_s;

  // Add at one extra bit so the overflow is visible, clamp, then rectify.
  always_comb begin
    sum_s = $signed({acc_i[BW-1], acc_i}) + $signed({add_i[BW-1], add_i});
    sat_o = 1'b0;
    res_o = sum_s[BW-1:0];
    if (sum_s > MAX_V) begin
      res_o = MAX_V[BW-1:0];
      sat_o = 1'b1;
    end else if (sum_s < MIN_V) begin
      res_o = MIN_V[BW-1:0];
      sat_o = 1'b1;
    end else begin
      res_o = sum_s[BW-1:0];
    end
    if (relu_en_i && res_o[BW-1]) begin
      res_o = '0;
    end else begin
      res_o = res_o;
    end
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Moves psum vectors from the OFIFO either into pmem (WS read-modify-write
// accumulate) or out on a valid/ready stream (OS), under a small FSM.
module psum_accum_ctrl
  import psum_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11,
  parameter int cnt_w   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   relu_en,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [cnt_w-1:0]       vec_cnt,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] psum_in,
  output logic                   ofifo_rd,
  output logic                   pmem_cen,
  output logic                   pmem_wen,
  output logic [addr_w-1:0]      pmem_addr,
  output logic [psum_bw*col-1:0] pmem_d,
  input  logic [psum_bw*col-1:0] pmem_q,
  output logic [psum_bw*col-1:0] sfp_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int VW = psum_bw * col;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              relu_q, relu_d;
  logic [addr_w-1:0] cur_addr_q, cur_addr_d;
  logic [cnt_w-1:0]  remaining_q, remaining_d;
  logic [VW-1:0]     psum_q, psum_d;
  logic [VW-1:0]     sfp_out_q, sfp_out_d;
  logic              sat_q, sat_d;

  logic [VW-1:0]     lane_acc_s, lane_add_s, lane_res_s;
  logic [col-1:0]    lane_sat_s;
  logic              last_s;

  // The lanes accumulate pmem_q + psum_r in WRITE; elsewhere they only
  // rectify the OFIFO head so the OS result can be registered at the pop.
  assign lane_acc_s = (state_q == WRITE) ? pmem_q : '0;
  assign lane_add_s = (state_q == WRITE) ? psum_q : psum_in;
  assign last_s     = (remaining_q == cnt_w'(32'd1));

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_sat #(.BW(psum_bw)) u_lane (
      .acc_i     (lane_acc_s[i*psum_bw +: psum_bw]),
      .add_i     (lane_add_s[i*psum_bw +: psum_bw]),
      .relu_en_i (relu_q),
      .res_o     (lane_res_s[i*psum_bw +: psum_bw]),
      .sat_o     (lane_sat_s[i])
    );
  end

  assign sfp_out  = sfp_out_q;
  assign sat_flag = sat_q;
  assign busy     = (state_q != IDLE);

  // Next-state and strobe logic; while reset is high every strobe is held
  // inactive so an aborted job cannot touch the SRAM or pop the OFIFO.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    relu_d      = relu_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    psum_d      = psum_q;
    sfp_out_d   = sfp_out_q;
    sat_d       = sat_q;
    ofifo_rd    = 1'b0;
    pmem_cen    = 1'b1;
    pmem_wen    = 1'b1;
    pmem_addr   = '0;
    pmem_d      = '0;
    out_valid   = 1'b0;
    done        = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d      = mode;
            relu_d      = relu_en;
            cur_addr_d  = base_addr;
            remaining_d = vec_cnt;
            sat_d       = 1'b0;
            state_d     = (vec_cnt == '0) ? DONE : FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          if (ofifo_valid) begin
            ofifo_rd = 1'b1;
            psum_d   = psum_in;
            if (mode_q == MODE_WS) begin
              pmem_cen  = 1'b0;
              pmem_addr = cur_addr_q;
              state_d   = WRITE;
            end else begin
              sfp_out_d = lane_res_s;
              state_d   = EMIT;
            end
          end else begin
            state_d = FETCH;
          end
        end
        WRITE: begin
          pmem_cen    = 1'b0;
          pmem_wen    = 1'b0;
          pmem_addr   = cur_addr_q;
          pmem_d      = lane_res_s;
          sat_d       = sat_q | (|lane_sat_s);
          cur_addr_d  = cur_addr_q + addr_w'(32'd1);
          remaining_d = remaining_q - cnt_w'(32'd1);
          state_d     = last_s ? DONE : FETCH;
        end
        EMIT: begin
          out_valid = 1'b1;
          if (out_ready) begin
            remaining_d = remaining_q - cnt_w'(32'd1);
            state_d     = last_s ? DONE : FETCH;
          end else begin
            state_d = EMIT;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      relu_q      <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      psum_q      <= '0;
      sfp_out_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      relu_q      <= relu_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      psum_q      <= psum_d;
      sfp_out_q   <= sfp_out_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench for psum_accum_ctrl: OFIFO and pmem models, write/emit
// scoreboards, a WS vector table and hand-written multi-cycle sequences.
module tb_psum_accum_ctrl;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 11;
  localparam int CW  = 12;
  localparam int VW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset, start, mode, relu_en, out_ready;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] vec_cnt;
  logic          ofifo_valid = 1'b0;
  logic [VW-1:0] psum_in = '0;
  logic [VW-1:0] pmem_q = '0;
  logic          ofifo_rd, pmem_cen, pmem_wen, out_valid, busy, done, sat_flag;
  logic [AW-1:0] pmem_addr;
  logic [VW-1:0] pmem_d, sfp_out;

  psum_accum_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .relu_en(relu_en),
    .base_addr(base_addr), .vec_cnt(vec_cnt), .ofifo_valid(ofifo_valid),
    .psum_in(psum_in), .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen),
    .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_d(pmem_d),
    .pmem_q(pmem_q), .sfp_out(sfp_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  logic [VW-1:0]    mem [0:2047];
  logic [VW-1:0]    fifo_q[$];
  logic [AW+VW-1:0] exp_wr[$];
  logic [VW-1:0]    exp_emit[$];
  logic             gate = 1'b0;
  logic             cur_mode = 1'b0;
  int               n_chk = 0, n_fail = 0, acc_cnt = 0, rd_cnt = 0;
  logic             rd_s = 1'b0, cen_s = 1'b1, wen_s = 1'b1;
  logic [AW-1:0]    addr_s = '0;
  logic [VW-1:0]    d_s = '0;

  typedef struct {
    int   acc;
    int   add;
    logic relu;
    int   res;
    logic sat;
  } vec_t;
  vec_t tbl[8];

  int v1[8]  = '{-4, 7, -1, 2, -32768, 32767, 0, 100};
  int e1[8]  = '{ 0, 7,  0, 2,      0, 32767, 0, 100};
  int v2[8]  = '{ 1, -2, 3, -4, 5, -6, 7, -8};
  int e2[8]  = '{ 1,  0, 3,  0, 5,  0, 7,  0};

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    for (int j = 0; j < COL; j++) r[j*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] vec_from(input int a[8]);
    logic [VW-1:0] r;
    for (int j = 0; j < COL; j++) r[j*BW +: BW] = BW'(a[j]);
    return r;
  endfunction

  // Strobe snapshot and scoreboard checks, taken mid-cycle.
  initial forever begin
    @(negedge clk);
    rd_s = ofifo_rd; cen_s = pmem_cen; wen_s = pmem_wen;
    addr_s = pmem_addr; d_s = pmem_d;
    if (rd_s) rd_cnt++;
    if (!cen_s) acc_cnt++;
    if (!cen_s && !wen_s) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, want no write", addr_s, d_s);
      end else begin
        logic [AW+VW-1:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", VW'(addr_s), VW'(e[VW +: AW]));
        chk("wr_data", d_s, e[VW-1:0]);
      end
    end
    if (out_valid && out_ready) begin
      if (exp_emit.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_emit: got %0h, want no emit", sfp_out);
      end else begin
        chk("emit_data", sfp_out, exp_emit.pop_front());
      end
    end
    if (out_valid && cur_mode == 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL ws_out_valid: got out_valid 1, want 0");
    end
  end

  // OFIFO and single-port pmem models, updated just after the clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!cen_s) begin
      if (!wen_s) mem[addr_s] = d_s;
      else        pmem_q = mem[addr_s];
    end
    ofifo_valid = gate && (fifo_q.size() > 0);
    psum_in     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Launch a job and wait (bounded) for done; optionally pulse a rogue start.
  task automatic run_job(input logic m, input logic r, input int b, input int c,
                         input int intrude, output int cyc);
    mode = m; relu_en = r; base_addr = AW'(b); vec_cnt = CW'(c);
    cur_mode = m; start = 1'b1; cyc = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (intrude > 0 && k == intrude) begin
        start = 1'b1; mode = 1'b1; base_addr = AW'(5); vec_cnt = CW'(1);
      end
      if (intrude > 0 && k == intrude + 1) start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    if (cyc == 0) begin
      n_chk++; n_fail++;
      $display("FAIL job_timeout: got no done, want done within 300 cycles");
    end
    tick();
  endtask

  initial begin
    int cyc;
    int a0;
    int r0;
    logic found;

    for (int i = 0; i < 2048; i++) mem[i] = '0;
    tbl[0] = '{5,      3,      1'b0, 8,      1'b0};
    tbl[1] = '{32000,  1000,   1'b0, 32767,  1'b1};
    tbl[2] = '{-32000, -1000,  1'b1, 0,      1'b1};
    tbl[3] = '{-32000, -1000,  1'b0, -32768, 1'b1};
    tbl[4] = '{-10,    4,      1'b1, 0,      1'b0};
    tbl[5] = '{-10,    4,      1'b0, -6,     1'b0};
    tbl[6] = '{32767,  0,      1'b0, 32767,  1'b0};
    tbl[7] = '{100,    -300,   1'b0, -200,   1'b0};

    reset = 1'b1; start = 1'b0; mode = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    base_addr = '0; vec_cnt = '0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cen", pmem_cen, 1'b1);
    chk("rst_wen", pmem_wen, 1'b1);
    chk("rst_addr", pmem_addr, '0);
    chk("rst_sfp", sfp_out, '0);
    chk("rst_flags", {ofifo_rd, out_valid, done, sat_flag}, 4'b0000);
    reset = 1'b0;
    tick();

    // WS vector table: one single-vector job per entry.
    gate = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem[100 + i] = splat(tbl[i].acc);
      fifo_q.push_back(splat(tbl[i].add));
      exp_wr.push_back({AW'(100 + i), splat(tbl[i].res)});
      run_job(1'b0, tbl[i].relu, 100 + i, 1, 0, cyc);
      chk("tbl_cycles", cyc, 3);
      chk("tbl_sat", sat_flag, tbl[i].sat);
      chk("tbl_mem", mem[100 + i], splat(tbl[i].res));
    end

    // WS basic: three vectors, 2 cycles each plus DONE.
    for (int i = 10; i < 13; i++) begin
      mem[i] = splat(5);
      fifo_q.push_back(splat(3));
      exp_wr.push_back({AW'(i), splat(8)});
    end
    run_job(1'b0, 1'b0, 10, 3, 0, cyc);
    chk("ws_cycles", cyc, 7);
    chk("ws_sat", sat_flag, 1'b0);
    for (int i = 10; i < 13; i++) chk("ws_mem", mem[i], splat(8));

    // OS with backpressure: result held for 4 cycles, no pmem access.
    a0 = acc_cnt;
    fifo_q.push_back(vec_from(v1));
    fifo_q.push_back(vec_from(v2));
    exp_emit.push_back(vec_from(e1));
    exp_emit.push_back(vec_from(e2));
    mode = 1'b1; relu_en = 1'b1; base_addr = AW'(0); vec_cnt = CW'(2);
    cur_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("os_valid_seen", found, 1'b1);
    for (int h = 0; h < 4; h++) begin
      chk("os_hold_data", sfp_out, vec_from(e1));
      chk("os_hold_valid", out_valid, 1'b1);
      if (h < 3) tick();
    end
    out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("os_done", found, 1'b1);
    tick();
    chk("os_no_pmem", acc_cnt - a0, 0);
    chk("os_all_emitted", exp_emit.size(), 0);
    out_ready = 1'b0;

    // Zero-length job: DONE right after IDLE, nothing popped.
    fifo_q.push_back(splat(77));
    r0 = rd_cnt;
    run_job(1'b0, 1'b0, 50, 0, 0, cyc);
    chk("cnt0_cycles", cyc, 1);
    chk("cnt0_no_pop", rd_cnt - r0, 0);
    chk("cnt0_fifo", fifo_q.size(), 1);

    // Address wrap 2047 -> 0, with a start pulse while busy.
    fifo_q.push_back(splat(-3));
    mem[2047] = splat(10);
    mem[0]    = splat(20);
    exp_wr.push_back({AW'(2047), splat(87)});
    exp_wr.push_back({AW'(0), splat(17)});
    run_job(1'b0, 1'b0, 2047, 2, 2, cyc);
    chk("wrap_cycles", cyc, 5);
    chk("wrap_mem_hi", mem[2047], splat(87));
    chk("wrap_mem_lo", mem[0], splat(17));
    chk("wrap_idle", busy, 1'b0);
    chk("wrap_sb_empty", exp_wr.size(), 0);

    // Empty OFIFO stall, then reset in WRITE: write suppressed.
    gate = 1'b0;
    fifo_q.push_back(splat(9));
    mem[200] = splat(1);
    mode = 1'b0; relu_en = 1'b0; base_addr = AW'(200); vec_cnt = CW'(2);
    cur_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_strobes", {ofifo_rd, pmem_cen, busy}, 3'b011);
      tick();
    end
    gate = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ofifo_rd) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_release", found, 1'b1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_write_blocked", {pmem_cen, pmem_wen}, 2'b11);
    tick();
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_pmem", {pmem_cen, pmem_wen, pmem_addr}, {2'b11, AW'(0)});
    chk("rst2_data", pmem_d, '0);
    chk("rst2_sfp", sfp_out, '0);
    chk("rst2_flags", {ofifo_rd, out_valid, done, sat_flag}, 4'b0000);
    reset = 1'b0;
    tick(); tick();
    chk("rst2_mem", mem[200], splat(1));
    chk("rst2_idle", busy, 1'b0);
    chk("final_sb", exp_wr.size() + exp_emit.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
- Parametrised successor to the core's output path: moves psum vectors out of the OFIFO under an FSM instead of raw per-cycle instruction bits.
- WS mode (mode=0): read-modify-write accumulate into the psum SRAM, with per-lane saturation and optional ReLU on write-back.
- OS mode (mode=1): pops the OFIFO, applies optional ReLU and streams results out on a valid/ready port; the psum SRAM is untouched.
- Sits between corelet OFIFO, pmem and the sfp_out consumer.

Parameters:
col, 8, number of psum lanes
psum_bw, 16, signed lane width
addr_w, 11, pmem address width (2048 words)
cnt_w, 12, vector-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle job launch; sampled only in IDLE
mode  in  1  0=WS accumulate, 1=OS stream
relu_en  in  1  apply ReLU to written (WS) or emitted (OS) value
base_addr  in  addr_w  first pmem word of the job
vec_cnt  in  cnt_w  number of vectors in the job
ofifo_valid  in  1  OFIFO has data (show-ahead)
psum_in  in  psum_bw*col  OFIFO head, valid while ofifo_valid
ofifo_rd  out  1  pop strobe
pmem_cen  out  1  active-low chip enable
pmem_wen  out  1  active-low write enable
pmem_addr  out  addr_w  pmem address
pmem_d  out  psum_bw*col  pmem write data
pmem_q  in  psum_bw*col  pmem read data, valid 1 cycle after read
sfp_out  out  psum_bw*col  OS result
out_valid  out  1  sfp_out valid
out_ready  in  1  consumer accepts
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
sat_flag  out  1  sticky: a lane saturated in the current job

Behaviour:
- Reset values: all state/counters zero, FSM=IDLE, ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_addr=0, pmem_d=0, sfp_out=0, out_valid=0, done=0, sat_flag=0. Reset mid-job aborts immediately, with no further SRAM access or pop.
- States: IDLE, FETCH, WRITE, EMIT, DONE.
- IDLE: on start, latch mode, relu_en, base_addr -> cur_addr, vec_cnt -> remaining, and clear sat_flag. If vec_cnt==0 go to DONE, else go to FETCH. start in any other state is ignored.
- FETCH: wait while !ofifo_valid, with all strobes inactive. When ofifo_valid:
  - ofifo_rd=1 for exactly one cycle; psum_in is captured into psum_r.
  - WS: same cycle pmem_cen=0, pmem_wen=1, pmem_addr=cur_addr; next state WRITE.
  - OS: next state EMIT.
- WRITE (WS):
  - Per lane, sum = sext(pmem_q) + sext(psum_r) at psum_bw+1 bits, clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Any clamp sets sat_flag.
  - If relu_en, negative results become 0 after the clamp.
  - pmem_cen=0, pmem_wen=0, pmem_addr=cur_addr, pmem_d=result.
  - cur_addr+1 wraps modulo 2^addr_w; remaining-1. Next state is DONE if remaining==1, else FETCH.
  - Throughput is 2 cycles/vector minimum. Read and write never share a cycle (single-port SRAM).
- EMIT (OS):
  - out_valid=1, sfp_out = relu_en ? per-lane ReLU(psum_r) : psum_r, registered and held stable until out_ready.
  - On out_valid&&out_ready: remaining-1; next state is DONE if remaining==1, else FETCH. out_valid drops the next cycle.
  - pmem stays idle (cen=1).
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- WS mode never asserts out_valid; OS mode never asserts pmem_cen=0.
- Address wrap: base_addr=2047 with vec_cnt=2 accesses 2047 then 0.
- OFIFO empty mid-job: stall in FETCH indefinitely; no timeout.

Decomposition:
- Shared package psum_pkg:
  - state enum (IDLE, FETCH, WRITE, EMIT, DONE)
  - mode constants MODE_WS=0, MODE_OS=1
  - saturation min/max constants derived from psum_bw
- One sub-module, psum_lane_sat: one lane of adder, clamp, ReLU and saturation flag, instantiated col times by generate.

Test Plan:
- WS basic: pmem[10..12] preloaded with lane values 5; three OFIFO vectors of 3, base=10, cnt=3 -> pmem[10..12] all lanes 8; done after 6 active cycles plus DONE; sat_flag=0.
- WS saturation+ReLU: pmem=32000, psum=1000 -> 32767, sat_flag=1. pmem=-32000, psum=-1000, relu_en=1 -> 0 written, sat_flag=1.
- OS backpressure: cnt=2, psum lanes {-4,7,...}, relu_en=1, out_ready low 3 cycles -> sfp_out {0,7,...} held stable 4 cycles; second vector emitted; no pmem access.
- Edge cases: cnt=0 -> done the cycle after IDLE exit with no pop. Base=2047, cnt=2 -> addresses 2047 then 0. start while busy -> ignored.
- Empty OFIFO stall plus reset: ofifo_valid low 5 cycles in FETCH -> no strobes. Assert reset mid-WRITE -> all outputs return to reset values next cycle and no write lands.
